adc_sample_averager: RTL and testbench
======================================

# adc_sample_averager

Downstream consumer of the ADC108S102 serial interface. Detects each completed conversion frame from the interface's `cs_n`, captures the 10-bit `data` word, and rejects frames flagged by `check`. Accepted samples feed a power-of-two boxcar moving average whose result, with a one-cycle valid strobe, goes to the display/DAC path.

## Interface

Parameters:

- `W`, 10, sample width; matches the interface `data` width.
- `LOG2N`, 3, log2 of the window length; N = 2^LOG2N, legal range 1..6.
- `ERRW`, 8, width of the saturating reject counter.

Ports:

- `clk` in 1: system clock, the same clock that drives the ADC interface.
- `rst_n` in 1: reset, **synchronous and active-low**.
- `cs_n` in 1: frame strobe from the ADC interface. Its rising edge marks a new `data` word.
- `data` in W: sample from the ADC interface. It is stable for at least one full frame after the `cs_n` rise.
- `check` in 1: frame-error flag from the ADC interface; 1 means the frame is bad.
- `clr` in 1: synchronous clear. It restarts the warm-up without affecting `err_cnt`.
- `avg` out W: moving-average result.
- `avg_valid` out 1: one-cycle pulse when `avg` updates.
- `filled` out 1: high once N samples have been accepted since the last reset or clear.
- `err_cnt` out ERRW: count of rejected frames, saturating.

## Operation

- **`cs_n` synchronizer**: two flops reset to 1, plus a delay flop. `rise = s2 & ~s3`. Because the flops reset high, no spurious edge is generated after reset.
- **FSM states**: S_WAIT, S_CAP, S_UPD, S_OUT. Reset state is S_WAIT.
  - S_WAIT: on `rise`, go to S_CAP.
  - S_CAP: register `data` into `smp` and `check` into `bad`.
    - If `bad`, increment `err_cnt` (hold at 2^ERRW-1) and return to S_WAIT.
    - Otherwise go to S_UPD.
  - S_UPD: perform all of the following in one cycle, then go to S_OUT.
    - `sum <= sum + smp - buf[ptr]`.
    - `buf[ptr] <= smp`.
    - `ptr <= ptr + 1`, wrapping modulo N.
    - `fcnt` increments, saturating at N.
  - S_OUT:
    - `avg <= sum[W+LOG2N-1:LOG2N]`, a truncating divide.
    - `avg_valid` pulses only if `fcnt == N`.
    - Return to S_WAIT.
- **Widths**:
  - `sum` is W+LOG2N bits and never overflows.
  - `buf` is N entries of W bits.
  - `ptr` is LOG2N bits.
  - `fcnt` is LOG2N+1 bits.
- **Warm-up**: because `buf` is zero-cleared, `sum` stays exact during warm-up. `avg` is updated but `avg_valid` stays 0 until `filled`.
- **`filled`**: equals `fcnt == N`, registered. It is sticky until reset or `clr`.
- **`clr`**: has priority over everything except reset. It zeroes `buf`, `sum`, `ptr`, `fcnt`, `avg` and `filled`, forces S_WAIT, and does not change `err_cnt`.
- **Reset values**: `avg` = 0, `avg_valid` = 0, `filled` = 0, `err_cnt` = 0, FSM = S_WAIT. All internal registers are 0 except the sync flops, which are 1.
- **Reset or `clr` mid-frame**: an in-flight sample is discarded. A `rise` that arrives while not in S_WAIT is ignored.

## Timing

- **Edge detection**: the `cs_n` rise reaches `rise` on the 3rd `clk` edge.
- **Sampling**: `data` is sampled in S_CAP, 1 cycle after `rise`.
- **Latency**: `avg_valid` asserts 3 cycles after `rise`, i.e. about 6 `clk` after the `cs_n` rise.
- **Processing window**: 4 cycles per frame. This is far shorter than the frame period (17 sclk, each ≥ 4 clk), so back-to-back frames are never dropped.
- **`avg_valid`**: exactly 1 cycle wide. `avg` holds its value between pulses.
- **Simultaneous `clr` and `rise`**: `clr` wins and the edge is lost.

## Structure

- **Package `adc_avg_pkg`**: holds the FSM state encoding (2-bit localparams S_WAIT=0, S_CAP=1, S_UPD=2, S_OUT=3) and the default `W`=10.
- **Sub-module `sync_rise_detect`**: the 2-flop synchronizer plus rise detector. It takes a reset-value parameter and is reusable for other ADC/DAC strobes.
- **Top-level contents**: the FSM, buffer, accumulator and counters.

## Test plan

- **Warm-up**: after reset, 8 frames with `data` = 100, `check` = 0 → `avg_valid` stays 0 for frames 1-7; at frame 8 `avg_valid` pulses with `avg` = 100 and `filled` = 1.
- **Sliding window**: continue from the warm-up state with 8 frames of `data` = 900 → `avg` = 200, 300, … 900, one step per frame; `sum` never exceeds 7200.
- **Truncation**: buffer holds seven 0s, then one 7 → `avg` = 0; after eight 1023s → `avg` = 1023.
- **Reject path**: a frame with `check` = 1 → `err_cnt` increments, no `avg_valid` pulse, buffer unchanged. 300 bad frames → `err_cnt` = 255.
- **Clear**: pulse `clr` after fill → `filled` = 0, `avg` = 0, `err_cnt` unchanged; 8 more frames are needed before the next `avg_valid`.
- **Reset**: assert `rst_n` = 0 during S_UPD, then release while `cs_n` = 1 → all outputs are 0 and no `avg_valid` fires until 8 new frames arrive.

Source files
------------

// File: rtl/adc_avg_pkg.sv
// Shared constants for the ADC sample averager: FSM state encoding and default sample width.
package adc_avg_pkg;

    localparam int W_DEFAULT = 10;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_CAP  = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer plus delay flop producing a one-cycle rising-edge pulse.
// Resetting the flops high keeps a strobe that idles high from producing an edge out of reset.
module sync_rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= i_sig;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/adc_sample_averager.sv
// Captures ADC frames on the cs_n rise, rejects flagged frames and keeps a 2^LOG2N boxcar average.
//   state  | meaning
//   S_WAIT | idle, waiting for a cs_n rise
//   S_CAP  | capture data; bad frames bump err_cnt and return to S_WAIT
//   S_UPD  | slide the window: update sum, buffer slot, pointer and fill count
//   S_OUT  | publish avg; strobe avg_valid once the window is full
module adc_sample_averager
    import adc_avg_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int LOG2N = 3,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cs_n,
    input  logic [W-1:0]    data,
    input  logic            check,
    input  logic            clr,
    output logic [W-1:0]    avg,
    output logic            avg_valid,
    output logic            filled,
    output logic [ERRW-1:0] err_cnt
);

    localparam int N  = 1 << LOG2N;
    localparam int SW = W + LOG2N;
    localparam logic [LOG2N:0] FCNT_FULL = (LOG2N + 1)'(N);

    logic            w_rise;
    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            w_cap;
    logic            w_err_inc;
    logic            w_upd;
    logic            w_out;

    logic [W-1:0]    r_smp;
    logic [W-1:0]    r_buf [N];
    logic [SW-1:0]   r_sum;
    logic [LOG2N-1:0] r_ptr;
    logic [LOG2N:0]  r_fcnt;
    logic [W-1:0]    r_avg;
    logic            r_avg_valid;
    logic            r_filled;
    logic [ERRW-1:0] r_err_cnt;

    sync_rise_detect #(.RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (cs_n),
        .o_rise (w_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT:  if (w_rise) w_next = S_CAP;
            S_CAP:   w_next = check ? S_WAIT : S_UPD;
            S_UPD:   w_next = S_OUT;
            S_OUT:   w_next = S_WAIT;
            default: w_next = S_WAIT;
        endcase
    end

    always_comb begin
        w_cap     = (r_state == S_CAP);
        w_err_inc = w_cap & check;
        w_upd     = (r_state == S_UPD);
        w_out     = (r_state == S_OUT);
    end

    // clr wipes the window but leaves the reject count alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_smp       <= '0;
            r_sum       <= '0;
            r_ptr       <= '0;
            r_fcnt      <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_filled    <= 1'b0;
            r_err_cnt   <= '0;
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
        end else begin
            r_avg_valid <= 1'b0;
            if (clr) begin
                r_smp    <= '0;
                r_sum    <= '0;
                r_ptr    <= '0;
                r_fcnt   <= '0;
                r_avg    <= '0;
                r_filled <= 1'b0;
                for (int i = 0; i < N; i++) r_buf[i] <= '0;
            end else begin
                if (w_cap) r_smp <= data;
                if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
                if (w_upd) begin
                    r_sum        <= r_sum + SW'(r_smp) - SW'(r_buf[r_ptr]);
                    r_buf[r_ptr] <= r_smp;
                    r_ptr        <= r_ptr + 1'b1;
                    if (r_fcnt != FCNT_FULL) r_fcnt <= r_fcnt + 1'b1;
                end
                if (w_out) begin
                    r_avg       <= r_sum[SW-1:LOG2N];
                    r_avg_valid <= (r_fcnt == FCNT_FULL);
                end
                r_filled <= (r_fcnt == FCNT_FULL);
            end
        end
    end

    assign avg       = r_avg;
    assign avg_valid = r_avg_valid;
    assign filled    = r_filled;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: a window-of-samples model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_adc_sample_averager;

    localparam int W     = 10;
    localparam int LOG2N = 3;
    localparam int ERRW  = 8;
    localparam int N     = 1 << LOG2N;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cs_n;
    logic [W-1:0]    data;
    logic            check;
    logic            clr;
    logic [W-1:0]    avg;
    logic            avg_valid;
    logic            filled;
    logic [ERRW-1:0] err_cnt;

    adc_sample_averager #(.W(W), .LOG2N(LOG2N), .ERRW(ERRW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .data      (data),
        .check     (check),
        .clr       (clr),
        .avg       (avg),
        .avg_valid (avg_valid),
        .filled    (filled),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    int win[$];
    int acc;
    int exp_avg;
    int exp_err;
    bit exp_valid;
    bit exp_filled;

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        win.delete();
        acc        = 0;
        exp_avg    = 0;
        exp_filled = 1'b0;
        exp_valid  = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        exp_err = 0;
    endtask

    // Average of the last N accepted samples, missing slots count as zero
    task automatic model_accept(input int d);
        int s;
        win.push_back(d);
        if (win.size() > N) void'(win.pop_front());
        s = 0;
        foreach (win[i]) s += win[i];
        exp_avg = s / N;
        acc++;
        exp_filled = (acc >= N);
        exp_valid  = exp_filled;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("cyc_avg_valid", int'(avg_valid), int'(exp_valid));
            check_val("cyc_avg",       int'(avg),       exp_avg);
            check_val("cyc_filled",    int'(filled),    int'(exp_filled));
            check_val("cyc_err_cnt",   int'(err_cnt),   exp_err);
        end
    end

    // cs_n low for a few cycles, then rises with the new word; model updates land on the
    // cycles the outputs are due: err_cnt 4 edges after the rise, avg 6 edges after.
    task automatic frame(input int d, input bit bad);
        @(posedge clk); #1 cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 data = W'(d); check = bad; cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 if (bad) exp_err = (exp_err < ERR_MAX) ? exp_err + 1 : ERR_MAX;
        repeat (2) @(posedge clk);
        #1 if (!bad) model_accept(d);
        @(posedge clk);
        #1 exp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; data = '0; check = 1'b0; clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;
        check_val("rst_avg",       int'(avg),       0);
        check_val("rst_avg_valid", int'(avg_valid), 0);
        check_val("rst_filled",    int'(filled),    0);
        check_val("rst_err_cnt",   int'(err_cnt),   0);

        for (int i = 0; i < N; i++) begin
            frame(100, 1'b0);
            if (i == N - 2) check_val("warmup_not_filled", int'(filled), 0);
        end
        check_val("warmup_avg",    int'(avg),    100);
        check_val("warmup_filled", int'(filled), 1);

        for (int k = 1; k <= N; k++) begin
            frame(900, 1'b0);
            check_val("slide_avg", int'(avg), 100 + 100 * k);
        end

        for (int i = 0; i < N - 1; i++) frame(0, 1'b0);
        frame(7, 1'b0);
        check_val("trunc_avg_7", int'(avg), 0);

        frame(1000, 1'b1);
        check_val("reject_err_cnt", int'(err_cnt), 1);
        check_val("reject_avg",     int'(avg),     0);
        frame(1023, 1'b0);
        check_val("after_reject_avg", int'(avg), 128);

        for (int i = 0; i < N; i++) frame(1023, 1'b0);
        check_val("trunc_avg_max", int'(avg), 1023);

        for (int i = 0; i < 300; i++) frame(5, 1'b1);
        check_val("err_saturate", int'(err_cnt), 255);
        check_val("err_no_avg_change", int'(avg), 1023);

        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0; model_clear();
        check_val("clr_filled",  int'(filled),  0);
        check_val("clr_avg",     int'(avg),     0);
        check_val("clr_err_cnt", int'(err_cnt), 255);
        for (int i = 0; i < N - 1; i++) frame(50, 1'b0);
        check_val("clr_refill_not_filled", int'(filled), 0);
        frame(50, 1'b0);
        check_val("clr_refill_avg",    int'(avg),    50);
        check_val("clr_refill_filled", int'(filled), 1);

        // clr lands on the same edge that would have seen the cs_n rise
        @(posedge clk); #1 cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 data = W'(77); check = 1'b0; cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0; model_clear();
        repeat (6) @(posedge clk); #1;
        check_val("clr_rise_avg",    int'(avg),    0);
        check_val("clr_rise_filled", int'(filled), 0);

        for (int i = 0; i < N; i++) frame(40, 1'b0);
        check_val("pre_reset_avg", int'(avg), 40);

        // reset lands while the FSM is in S_UPD; cs_n stays high across the release
        @(posedge clk); #1 cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 data = W'(333); check = 1'b0; cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0; chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; model_reset(); chk_en = 1'b1;
        repeat (4) @(posedge clk); #1;
        check_val("midrst_avg",     int'(avg),     0);
        check_val("midrst_filled",  int'(filled),  0);
        check_val("midrst_err_cnt", int'(err_cnt), 0);
        for (int i = 0; i < N - 1; i++) frame(60, 1'b0);
        check_val("midrst_not_filled", int'(filled), 0);
        frame(60, 1'b0);
        check_val("midrst_refill_avg",    int'(avg),    60);
        check_val("midrst_refill_filled", int'(filled), 1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
